// File: rtl/memory_port_arbiter_if.sv
// Bus bundle for memory_port_arbiter.
// Groups the MFU request port, the loader write port, the RAM port, the byte
// I/O port and the CDB result port. The slave modport is the arbiter's view;
// the master modport is the surrounding system's view.
interface memory_port_arbiter_if #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned INSTR_W  = 4,
  parameter int unsigned RSV_ID_W = 4
);
  localparam int unsigned CDB_W = RSV_ID_W + DATA_W;

  // MFU request port
  logic                m_valid;
  logic [INSTR_W-1:0]  m_opcode;
  logic [RSV_ID_W-1:0] m_rsv_id;
  logic [DATA_W-1:0]   m_address;
  logic [DATA_W-1:0]   m_data;
  logic                m_ready;
  // Host program loader write port
  logic                l_valid;
  logic [DATA_W-1:0]   l_address;
  logic [DATA_W-1:0]   l_data;
  logic                l_ready;
  // Single-port data RAM
  logic                ram_en;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_wdata;
  logic [DATA_W-1:0]   ram_rdata;
  // Byte I/O
  logic                io_rx_valid;
  logic [7:0]          io_rx_data;
  logic                io_rx_ready;
  logic                io_tx_valid;
  logic [7:0]          io_tx_data;
  logic                io_tx_ready;
  // CDB result {rsv_id, data}
  logic [CDB_W-1:0]    o_cdb;
  logic                o_cdb_valid;
  logic                o_cdb_ready;

  modport slave (
    input  m_valid, m_opcode, m_rsv_id, m_address, m_data,
    output m_ready,
    input  l_valid, l_address, l_data,
    output l_ready,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata,
    input  io_rx_valid, io_rx_data,
    output io_rx_ready,
    output io_tx_valid, io_tx_data,
    input  io_tx_ready,
    output o_cdb, o_cdb_valid,
    input  o_cdb_ready
  );

  modport master (
    output m_valid, m_opcode, m_rsv_id, m_address, m_data,
    input  m_ready,
    output l_valid, l_address, l_data,
    input  l_ready,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata,
    output io_rx_valid, io_rx_data,
    input  io_rx_ready,
    input  io_tx_valid, io_tx_data,
    output io_tx_ready,
    input  o_cdb, o_cdb_valid,
    output o_cdb_ready
  );
endinterface

// File: rtl/memory_port_arbiter.sv
// Memory port arbiter: owns the single-port data RAM and byte I/O port behind
// the memory functional unit. Round-robin shares the RAM between the MFU and
// the program loader, sequences RAM read latency and I/O handshakes, and
// returns load/input results on the CDB as {rsv_id, data}. One MFU
// transaction is in flight at a time.
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - memory_port_arbiter_if.slave (MFU, loader, RAM, I/O, CDB ports)
// Opcodes: 0 LOAD, 1 LOADB, 2 LOADR, 3 INPUT, 4 STORE, 5 STOREB, 6 STORER,
//          7 OUTPUT; anything else is accepted and discarded.
module memory_port_arbiter #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned RAM_LAT  = 2,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned INSTR_W  = 4,
  parameter int unsigned RSV_ID_W = 4
) (
  input logic                   clk,
  input logic                   rst,
  memory_port_arbiter_if.slave  bus
);
  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RAM_LAT - 1);

  localparam logic [INSTR_W-1:0] OP_LOAD   = INSTR_W'(0);
  localparam logic [INSTR_W-1:0] OP_LOADB  = INSTR_W'(1);
  localparam logic [INSTR_W-1:0] OP_LOADR  = INSTR_W'(2);
  localparam logic [INSTR_W-1:0] OP_INPUT  = INSTR_W'(3);
  localparam logic [INSTR_W-1:0] OP_STORE  = INSTR_W'(4);
  localparam logic [INSTR_W-1:0] OP_STOREB = INSTR_W'(5);
  localparam logic [INSTR_W-1:0] OP_STORER = INSTR_W'(6);
  localparam logic [INSTR_W-1:0] OP_OUTPUT = INSTR_W'(7);

  localparam logic GRANT_MFU    = 1'b0;
  localparam logic GRANT_LOADER = 1'b1;

  typedef enum logic [2:0] {
    IDLE, RD_WAIT, IN_WAIT, OUT_WAIT, CDB_HOLD
  } state_t;

  state_t              state, next_state;
  logic                last_grant;
  logic [CNT_W-1:0]    lat_cnt;
  logic [RSV_ID_W-1:0] rsv_q;
  logic [DATA_W-1:0]   cdb_data;
  logic [7:0]          tx_byte;

  logic is_load, is_store, is_input, is_output;
  logic grant_m, grant_l, idle_ok;

  // Upper address bits are deliberately ignored (no range fault).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.m_address[DATA_W-1:ADDR_W],
                              bus.l_address[DATA_W-1:ADDR_W]};

  // Opcode decode
  always_comb begin
    is_load   = (bus.m_opcode == OP_LOAD)  || (bus.m_opcode == OP_LOADB) ||
                (bus.m_opcode == OP_LOADR);
    is_store  = (bus.m_opcode == OP_STORE) || (bus.m_opcode == OP_STOREB) ||
                (bus.m_opcode == OP_STORER);
    is_input  = (bus.m_opcode == OP_INPUT);
    is_output = (bus.m_opcode == OP_OUTPUT);
  end

  // Round-robin grant; only in IDLE, and never while reset is asserted.
  always_comb begin
    idle_ok = (state == IDLE) && !rst;
    grant_m = idle_ok && bus.m_valid &&
              (!bus.l_valid || (last_grant == GRANT_LOADER));
    grant_l = idle_ok && bus.l_valid &&
              (!bus.m_valid || (last_grant == GRANT_MFU));
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (grant_m) begin
          if (is_load)        next_state = RD_WAIT;
          else if (is_input)  next_state = IN_WAIT;
          else if (is_output) next_state = OUT_WAIT;
        end
      end
      RD_WAIT:  if (lat_cnt == '0)     next_state = CDB_HOLD;
      IN_WAIT:  if (bus.io_rx_valid)   next_state = CDB_HOLD;
      OUT_WAIT: if (bus.io_tx_ready)   next_state = IDLE;
      CDB_HOLD: if (bus.o_cdb_ready)   next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Output logic; RAM strobe and ready signals follow the grant in the same cycle.
  always_comb begin
    bus.m_ready     = grant_m;
    bus.l_ready     = grant_l;
    bus.ram_en      = 1'b0;
    bus.ram_we      = 1'b0;
    bus.ram_addr    = '0;
    bus.ram_wdata   = '0;
    bus.io_rx_ready = 1'b0;
    bus.io_tx_valid = 1'b0;
    bus.io_tx_data  = tx_byte;
    bus.o_cdb_valid = 1'b0;
    bus.o_cdb       = {rsv_q, cdb_data};
    if (grant_l) begin
      bus.ram_en    = 1'b1;
      bus.ram_we    = 1'b1;
      bus.ram_addr  = bus.l_address[ADDR_W-1:0];
      bus.ram_wdata = bus.l_data;
    end else if (grant_m && (is_load || is_store)) begin
      bus.ram_en    = 1'b1;
      bus.ram_we    = is_store;
      bus.ram_addr  = bus.m_address[ADDR_W-1:0];
      bus.ram_wdata = bus.m_data;
    end
    case (state)
      IN_WAIT:  bus.io_rx_ready = bus.io_rx_valid;
      OUT_WAIT: bus.io_tx_valid = 1'b1;
      CDB_HOLD: bus.o_cdb_valid = 1'b1;
      default:  ;
    endcase
  end

  // Datapath: arbitration history, latency counter, result and byte holding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= GRANT_LOADER;
      lat_cnt    <= '0;
      rsv_q      <= '0;
      cdb_data   <= '0;
      tx_byte    <= '0;
    end else begin
      // History only moves on contention
      if (grant_m && bus.l_valid) last_grant <= GRANT_MFU;
      if (grant_l && bus.m_valid) last_grant <= GRANT_LOADER;
      if (grant_m) rsv_q <= bus.m_rsv_id;
      if (grant_m && is_load) lat_cnt <= LAT_LOAD;
      else if (state == RD_WAIT && lat_cnt != '0) lat_cnt <= lat_cnt - CNT_W'(1);
      if (grant_m && is_output) tx_byte <= bus.m_data[7:0];
      if (state == RD_WAIT && lat_cnt == '0) cdb_data <= bus.ram_rdata;
      if (state == IN_WAIT && bus.io_rx_valid) cdb_data <= DATA_W'(bus.io_rx_data);
    end
  end
endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed self-checking bench for memory_port_arbiter with a 2-cycle RAM model.
module tb_memory_port_arbiter;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 16;
  localparam logic [3:0] OP_LOAD   = 4'd0;
  localparam logic [3:0] OP_INPUT  = 4'd3;
  localparam logic [3:0] OP_STORE  = 4'd4;
  localparam logic [3:0] OP_OUTPUT = 4'd7;
  localparam logic [3:0] OP_BAD    = 4'hF;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  memory_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  memory_port_arbiter #(.ADDR_W(ADDR_W), .RAM_LAT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // RAM model: read data valid two cycles after the read strobe
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rd_p0, rd_p1;
  always @(posedge clk) begin
    if (bus.ram_en && bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_en && !bus.ram_we) rd_p0 <= mem[bus.ram_addr];
    rd_p1 <= rd_p0;
  end
  assign bus.ram_rdata = rd_p1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus.m_valid = 0; bus.m_opcode = '0; bus.m_rsv_id = '0;
    bus.m_address = '0; bus.m_data = '0;
    bus.l_valid = 0; bus.l_address = '0; bus.l_data = '0;
    bus.io_rx_valid = 0; bus.io_rx_data = '0; bus.io_tx_ready = 0;
    bus.o_cdb_ready = 0;

    // Reset state, with a request pending that must not be granted
    tick();
    bus.m_valid = 1; bus.m_opcode = OP_STORE; bus.l_valid = 1;
    samp();
    chk("rst_m_ready", 32'(bus.m_ready), 0);
    chk("rst_l_ready", 32'(bus.l_ready), 0);
    chk("rst_ram_en", 32'(bus.ram_en), 0);
    chk("rst_cdb_valid", 32'(bus.o_cdb_valid), 0);
    chk("rst_cdb", 32'(bus.o_cdb), 0);
    chk("rst_tx_valid", 32'(bus.io_tx_valid), 0);
    tick();
    bus.m_valid = 0; bus.l_valid = 0;
    rst = 1'b0;

    // MFU STORE alone: same-cycle write pulse, no CDB
    tick();
    bus.m_valid = 1; bus.m_opcode = OP_STORE; bus.m_address = 16'h0005; bus.m_data = 16'hDEAD;
    samp();
    chk("st_m_ready", 32'(bus.m_ready), 1);
    chk("st_ram_en", 32'(bus.ram_en), 1);
    chk("st_ram_we", 32'(bus.ram_we), 1);
    chk("st_ram_addr", 32'(bus.ram_addr), 5);
    chk("st_ram_wdata", 32'(bus.ram_wdata), 32'hDEAD);
    tick();
    bus.m_valid = 0;
    samp();
    chk("st_no_cdb", 32'(bus.o_cdb_valid), 0);

    // LOAD addr 5 rsv 3: CDB valid at accept+3, held while not ready
    tick();
    bus.m_valid = 1; bus.m_opcode = OP_LOAD; bus.m_rsv_id = 4'd3; bus.m_address = 16'h0005;
    samp();
    chk("ld_m_ready", 32'(bus.m_ready), 1);
    chk("ld_ram_en", 32'(bus.ram_en), 1);
    chk("ld_ram_we", 32'(bus.ram_we), 0);
    chk("ld_ram_addr", 32'(bus.ram_addr), 5);
    tick();
    bus.m_valid = 0;
    samp();
    chk("ld_wait1_valid", 32'(bus.o_cdb_valid), 0);
    tick();
    samp();
    chk("ld_wait2_valid", 32'(bus.o_cdb_valid), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) bus.o_cdb_ready = 1;
      samp();
      chk("ld_hold_valid", 32'(bus.o_cdb_valid), 1);
      chk("ld_hold_cdb", 32'(bus.o_cdb), 32'h3DEAD);
    end
    tick();
    bus.o_cdb_ready = 0;
    samp();
    chk("ld_cleared", 32'(bus.o_cdb_valid), 0);

    // Contention with stores only: grants alternate MFU, LOADER, ...
    for (int i = 0; i < 6; i++) begin
      tick();
      bus.m_valid = 1; bus.m_opcode = OP_STORE;
      bus.m_address = 16'(16'h0010 + i); bus.m_data = 16'(16'hA000 + i);
      bus.l_valid = 1;
      bus.l_address = 16'(16'h0020 + i); bus.l_data = 16'(16'hB000 + i);
      samp();
      chk("rr_m_ready", 32'(bus.m_ready), (i % 2 == 0) ? 1 : 0);
      chk("rr_l_ready", 32'(bus.l_ready), (i % 2 == 0) ? 0 : 1);
      chk("rr_ram_addr", 32'(bus.ram_addr), (i % 2 == 0) ? 32'(16 + i) : 32'(32 + i));
    end
    tick();
    bus.m_valid = 0; bus.l_valid = 0;

    // INPUT rsv 7, byte arrives after 5 cycles; loader stalled throughout
    tick();
    bus.m_valid = 1; bus.m_opcode = OP_INPUT; bus.m_rsv_id = 4'd7;
    bus.l_valid = 1; bus.l_address = 16'h0030; bus.l_data = 16'h5555;
    samp();
    chk("in_m_ready", 32'(bus.m_ready), 1);
    chk("in_l_ready_acc", 32'(bus.l_ready), 0);
    tick();
    bus.m_valid = 0;
    for (int i = 0; i < 5; i++) begin
      samp();
      chk("in_rx_ready_idle", 32'(bus.io_rx_ready), 0);
      chk("in_l_ready_wait", 32'(bus.l_ready), 0);
      tick();
    end
    bus.io_rx_valid = 1; bus.io_rx_data = 8'h41;
    samp();
    chk("in_rx_ready", 32'(bus.io_rx_ready), 1);
    chk("in_l_ready_rx", 32'(bus.l_ready), 0);
    tick();
    bus.io_rx_valid = 0; bus.o_cdb_ready = 1; bus.l_valid = 0;
    samp();
    chk("in_rx_ready_after", 32'(bus.io_rx_ready), 0);
    chk("in_cdb_valid", 32'(bus.o_cdb_valid), 1);
    chk("in_cdb", 32'(bus.o_cdb), 32'h70041);
    tick();
    bus.o_cdb_ready = 0;
    samp();
    chk("in_cleared", 32'(bus.o_cdb_valid), 0);

    // OUTPUT 0x1234: low byte held until io_tx_ready
    tick();
    bus.m_valid = 1; bus.m_opcode = OP_OUTPUT; bus.m_data = 16'h1234;
    samp();
    chk("out_m_ready", 32'(bus.m_ready), 1);
    chk("out_ram_en", 32'(bus.ram_en), 0);
    tick();
    bus.m_valid = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.io_tx_ready = 1;
      samp();
      chk("out_tx_valid", 32'(bus.io_tx_valid), 1);
      chk("out_tx_data", 32'(bus.io_tx_data), 32'h34);
      tick();
    end
    bus.io_tx_ready = 0;
    bus.l_valid = 1; bus.l_address = 16'h0040; bus.l_data = 16'h7777;
    samp();
    chk("out_done_tx", 32'(bus.io_tx_valid), 0);
    chk("out_done_cdb", 32'(bus.o_cdb_valid), 0);
    chk("out_idle_l_ready", 32'(bus.l_ready), 1);
    tick();
    bus.l_valid = 0;

    // Unknown opcode: accepted, no RAM/I/O/CDB activity
    bus.m_valid = 1; bus.m_opcode = OP_BAD;
    samp();
    chk("bad_m_ready", 32'(bus.m_ready), 1);
    chk("bad_ram_en", 32'(bus.ram_en), 0);
    tick();
    bus.m_valid = 0;
    samp();
    chk("bad_tx_valid", 32'(bus.io_tx_valid), 0);
    chk("bad_cdb_valid", 32'(bus.o_cdb_valid), 0);
    chk("bad_rx_ready", 32'(bus.io_rx_ready), 0);

    // Reset pulse during RD_WAIT drops the load
    tick();
    bus.m_valid = 1; bus.m_opcode = OP_LOAD; bus.m_rsv_id = 4'd2; bus.m_address = 16'h0005;
    samp();
    chk("rw_m_ready", 32'(bus.m_ready), 1);
    tick();
    bus.m_valid = 0;
    rst = 1'b1;
    #1;
    chk("rw_rst_cdb_valid", 32'(bus.o_cdb_valid), 0);
    chk("rw_rst_ram_en", 32'(bus.ram_en), 0);
    chk("rw_rst_cdb", 32'(bus.o_cdb), 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      samp();
      chk("rw_no_cdb", 32'(bus.o_cdb_valid), 0);
      tick();
    end

    // Next LOAD completes; upper address bits ignored (0xFC10 -> 0x010)
    bus.m_valid = 1; bus.m_opcode = OP_LOAD; bus.m_rsv_id = 4'd5; bus.m_address = 16'hFC10;
    samp();
    chk("ld2_m_ready", 32'(bus.m_ready), 1);
    chk("ld2_ram_addr", 32'(bus.ram_addr), 32'h010);
    tick();
    bus.m_valid = 0;
    samp();
    chk("ld2_wait1", 32'(bus.o_cdb_valid), 0);
    tick();
    samp();
    chk("ld2_wait2", 32'(bus.o_cdb_valid), 0);
    tick();
    bus.o_cdb_ready = 1;
    samp();
    chk("ld2_cdb_valid", 32'(bus.o_cdb_valid), 1);
    chk("ld2_cdb", 32'(bus.o_cdb), 32'h5A000);
    tick();
    bus.o_cdb_ready = 0;
    samp();
    chk("ld2_cleared", 32'(bus.o_cdb_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
